// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU.
// Sequences Fetch/Decode/Execute/Memory/Writeback one state per clock and
// drives every datapath enable/select from registered, state-decoded values.
// Optional build macro MULTICYCLE_CTRL_MEM_WAIT_EN adds a MemReady input that
// stalls FETCH, MEMRD and MEMWR until memory responds.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_BNE   = 6'd5,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ADDI  = 6'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchSel,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REXEC   = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_sel;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal;
  } ctrl_t;

  state_t     state, next_state;
  logic [5:0] op_q, next_op;
  ctrl_t      ctrl_q;
  logic       mem_ready;
  logic       stall_fetch;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // Moore output table: control word for a given state and latched opcode.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.ir_write = 1'b1;
                       c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_REXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RWB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                       c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
                       c.branch_sel = (op == OP_BNE); end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:  c.reg_write = 1'b1;
      S_ILLEGAL: c.illegal = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next-state and opcode-latch selection; the opcode is captured only in DECODE.
  always_comb begin
    next_state = S_FETCH;
    next_op    = op_q;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        next_op = Opcode;
        if (Opcode == OP_LW || Opcode == OP_SW)        next_state = S_MEMADR;
        else if (Opcode == OP_RTYPE)                   next_state = S_REXEC;
        else if (Opcode == OP_BEQ || Opcode == OP_BNE) next_state = S_BRANCH;
        else if (Opcode == OP_J)                       next_state = S_JUMP;
        else if (Opcode == OP_ADDI)                    next_state = S_ADDIEX;
        else                                           next_state = S_ILLEGAL;
      end
      S_MEMADR: next_state = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  next_state = S_RWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // State register, opcode latch and registered control word; reset abandons any instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_INIT;
      op_q   <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      op_q   <= next_op;
      ctrl_q <= decode_ctrl(next_state, next_op);
    end
  end

  // A stalled fetch must not advance the PC or reload the IR.
  assign stall_fetch = (state == S_FETCH) && !mem_ready;

  assign PCWrite     = ctrl_q.pc_write && !stall_fetch;
  assign IRWrite     = ctrl_q.ir_write && !stall_fetch;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign BranchSel   = ctrl_q.branch_sel;
  assign IorD        = ctrl_q.i_or_d;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUOp       = ctrl_q.alu_op;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign Illegal     = ctrl_q.illegal;
  assign State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process walks whole
// instructions (per-opcode state lists) and pushes the expected state and
// output word for every cycle; a monitor pops and compares on each falling edge.
module tb_multicycle_control;

  localparam logic [5:0] T_RTYPE = 6'd0, T_LW = 6'd35, T_SW = 6'd43, T_BEQ = 6'd4,
                         T_BNE = 6'd5, T_J = 6'd2, T_ADDI = 6'd8;

  typedef struct packed {
    logic       pcw, pcwc, bsel, iord, mrd, mwr, m2r, irw;
    logic [1:0] pcsrc, aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       rw, rdst, ill;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchSel, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, Illegal;
  logic [3:0] State;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fetch_stall = -1;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    .MemReady(mem_ready),
`endif
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchSel(BranchSel), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .RegDst(RegDst), .Illegal(Illegal), .State(State)
  );

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic outs_t exp_outs(input int st, input logic [5:0] op, input logic rdy);
    outs_t o;
    o = '0;
    case (st)
      1:  begin o.pcw = rdy; o.irw = rdy; o.mrd = 1'b1; o.srcb = 2'b01; end
      2:  o.srcb = 2'b11;
      3:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      5:  begin o.rw = 1'b1; o.m2r = 1'b1; end
      6:  begin o.mwr = 1'b1; o.iord = 1'b1; end
      7:  begin o.srca = 1'b1; o.aluop = 2'b10; end
      8:  begin o.rw = 1'b1; o.rdst = 1'b1; end
      9:  begin o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01;
                o.bsel = (op == T_BNE); end
      10: begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
      11: begin o.srca = 1'b1; o.srcb = 2'b10; end
      12: o.rw = 1'b1;
      13: o.ill = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue what this cycle must show.
  task automatic cyc(input int st, input logic rst, input logic [5:0] opc,
                     input logic rdy, input logic [5:0] iop);
    obs_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    Opcode    = opc;
    mem_ready = rdy;
    e.st = 4'(st);
    e.o  = exp_outs(st, iop, mem_ready);
    exp_q.push_back(e);
  endtask

  function automatic logic [5:0] fill(input int filler);
    return (filler < 0) ? 6'($urandom_range(0, 63)) : 6'(filler);
  endfunction

  // Run one instruction (or its first ncyc cycles, then reset if abort is set).
  task automatic run_instr(input logic [5:0] op, input int ncyc, input bit abort,
                           input int filler);
    int seq[$];
    int n;
    int stalls;
    bit last;
    logic rdy;
    case (op)
      T_LW:         seq = '{1, 2, 3, 4, 5};
      T_SW:         seq = '{1, 2, 3, 6};
      T_RTYPE:      seq = '{1, 2, 7, 8};
      T_ADDI:       seq = '{1, 2, 11, 12};
      T_BEQ, T_BNE: seq = '{1, 2, 9};
      T_J:          seq = '{1, 2, 10};
      default:      seq = '{1, 2, 13};
    endcase
    n = (ncyc <= 0 || ncyc > seq.size()) ? seq.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      last = abort && (i == n - 1);
      stalls = 0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
      if (seq[i] == 1) begin
        stalls = (fetch_stall >= 0) ? fetch_stall : $urandom_range(0, 2);
        fetch_stall = -1;
      end else if (seq[i] == 4 || seq[i] == 6) begin
        stalls = $urandom_range(0, 2);
      end
      rdy = last ? 1'($urandom_range(0, 1)) : 1'b1;
`else
      rdy = 1'b1;
`endif
      if (!last)
        for (int k = 0; k < stalls; k++) cyc(seq[i], 1'b0, fill(filler), 1'b0, op);
      cyc(seq[i], last, (seq[i] == 2) ? op : fill(filler), rdy, op);
    end
    if (abort) cyc(0, 1'b0, fill(filler), 1'b1, op);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [7];
    int r;
    tbl = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI};
    r = $urandom_range(0, 8);
    return (r < 7) ? tbl[r] : 6'($urandom_range(0, 63));
  endfunction

  // Monitor: compare every cycle's state and outputs against the queued expectation.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.st = State;
        a.o  = '{PCWrite, PCWriteCond, BranchSel, IorD, MemRead, MemWrite, MemtoReg,
                 IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle_check t=%0t: got state=%0d outs=%h, want state=%0d outs=%h",
                   $time, a.st, a.o, e.st, e.o);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized instruction stream.
  initial begin
    int len;
    reset     = 1'b1;
    Opcode    = T_LW;
    mem_ready = 1'b1;
    cyc(0, 1'b1, T_LW, 1'b1, T_LW);
    cyc(0, 1'b0, T_LW, 1'b1, T_LW);
    run_instr(T_LW, 0, 1'b0, T_LW);
    run_instr(T_BNE, 0, 1'b0, -1);
    run_instr(T_BEQ, 0, 1'b0, -1);
    run_instr(T_RTYPE, 0, 1'b0, T_SW);
    run_instr(6'd63, 0, 1'b0, -1);
    run_instr(T_SW, 4, 1'b1, -1);
    run_instr(T_J, 0, 1'b0, -1);
    run_instr(T_ADDI, 0, 1'b0, -1);
    fetch_stall = 3;
    run_instr(T_RTYPE, 0, 1'b0, -1);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(1, 5);
        run_instr(pick_op(), len, 1'b1, -1);
      end else begin
        run_instr(pick_op(), 0, 1'b0, -1);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
